// File: rtl/tmr_pkg.sv
`default_nettype none
// ============================================================================
// Module   : tmr_pkg
// Function : Shared register map and control-bit layout for the tmr_mc timer
// Revision : 1.0
// ============================================================================
package tmr_pkg;

    localparam logic [1:0] REG_CTRL = 2'd0;
    localparam logic [1:0] REG_DIV  = 2'd1;
    localparam logic [1:0] REG_CNT  = 2'd2;

    localparam int CTRL_ALARM   = 0;
    localparam int CTRL_IEN     = 1;
    localparam int CTRL_RUN     = 2;
    localparam int CTRL_ONESHOT = 3;
    localparam int CTRL_W       = 4;

    // Field order makes the packed value line up with the CTRL bit indices.
    typedef struct packed {
        logic oneshot;
        logic run;
        logic ien;
        logic alarm;
    } ctrl_t;

    localparam ctrl_t CTRL_RESET = '{oneshot: 1'b0, run: 1'b1, ien: 1'b0, alarm: 1'b0};

endpackage
`default_nettype wire

// File: rtl/tmr_chan.sv
`default_nettype none
// ============================================================================
// Module   : tmr_chan
// Function : One timer channel: down-counter, divisor, control bits and alarm
// Revision : 1.0
// ============================================================================
module tmr_chan
    import tmr_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_tick,
    input  logic              i_wr_ctrl,
    input  logic              i_wr_div,
    input  logic [CTRL_W-1:0] i_ctrl_data,
    input  logic [CNT_W-1:0]  i_div_data,
    output logic [CTRL_W-1:0] o_ctrl,
    output logic [CNT_W-1:0]  o_div,
    output logic [CNT_W-1:0]  o_count,
    output logic              o_irq
);

    ctrl_t            r_ctrl;
    logic [CNT_W-1:0] r_div;
    logic [CNT_W-1:0] r_cnt;
    logic             r_exp;
    logic             r_load;

    logic w_step;
    logic w_wrap;

    assign w_step = i_tick & r_ctrl.run;
    assign w_wrap = (r_cnt == CNT_W'(1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ctrl <= CTRL_RESET;
            r_div  <= '1;
            r_cnt  <= '1;
            r_exp  <= 1'b0;
            r_load <= 1'b0;
        end else begin
            r_load <= i_wr_div;
            r_exp  <= 1'b0;
            if (i_wr_div) begin
                r_div <= i_div_data;
            end

            // A pending reload overrides any tick arriving in the same cycle.
            if (r_load) begin
                r_cnt <= r_div;
            end else if (w_step && w_wrap) begin
                r_cnt <= r_div;
                r_exp <= 1'b1;
                if (r_ctrl.oneshot) begin
                    r_ctrl.run <= 1'b0;
                end
            end else if (w_step) begin
                r_cnt <= r_cnt - CNT_W'(1);
            end

            if (i_wr_ctrl) begin
                r_ctrl.ien     <= i_ctrl_data[CTRL_IEN];
                r_ctrl.run     <= i_ctrl_data[CTRL_RUN];
                r_ctrl.oneshot <= i_ctrl_data[CTRL_ONESHOT];
            end

            // An expiry must never be lost to a simultaneous software clear.
            if (r_exp) begin
                r_ctrl.alarm <= 1'b1;
            end else if (i_wr_ctrl) begin
                r_ctrl.alarm <= i_ctrl_data[CTRL_ALARM];
            end
        end
    end

    assign o_ctrl  = r_ctrl;
    assign o_div   = r_div;
    assign o_count = r_cnt;
    assign o_irq   = r_ctrl.ien & r_ctrl.alarm;

endmodule
`default_nettype wire

// File: rtl/tmr_mc.sv
`default_nettype none
// ============================================================================
// Module   : tmr_mc
// Function : Multi-channel interval timer with shared prescaler on the I/O bus
// Revision : 1.0
// ============================================================================
module tmr_mc
    import tmr_pkg::*;
#(
    parameter int NUM_CH   = 2,
    parameter int CNT_W    = 32,
    parameter int PRESCALE = 50000,
    parameter int AW       = $clog2(NUM_CH) + 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              wr,
    input  logic [AW-1:0]     addr,
    input  logic [31:0]       data_in,
    output logic [31:0]       data_out,
    output logic              wt,
    output logic [NUM_CH-1:0] irq
);

    localparam int PW  = $clog2(PRESCALE + 1);
    localparam int CHW = 5;

    logic [PW-1:0] r_presc;
    logic          r_tick;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_presc <= PW'(PRESCALE);
            r_tick  <= 1'b0;
        end else if (r_presc == PW'(1)) begin
            r_presc <= PW'(PRESCALE);
            r_tick  <= 1'b1;
        end else begin
            r_presc <= r_presc - PW'(1);
            r_tick  <= 1'b0;
        end
    end

    logic [CHW-1:0] w_chan;
    logic [1:0]     w_reg;

    assign w_reg = addr[1:0];

    // A single-channel build has no channel field in the address.
    generate
        if (NUM_CH == 1) begin : g_chan_one
            assign w_chan = '0;
        end else begin : g_chan_multi
            assign w_chan = CHW'(addr[AW-1:2]);
        end
    endgenerate

    logic [CTRL_W-1:0] w_ctrl [NUM_CH];
    logic [CNT_W-1:0]  w_div  [NUM_CH];
    logic [CNT_W-1:0]  w_cnt  [NUM_CH];
    logic [NUM_CH-1:0] w_wr_ctrl;
    logic [NUM_CH-1:0] w_wr_div;

    generate
        for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
            assign w_wr_ctrl[g] = en & wr & (w_chan == CHW'(g)) & (w_reg == REG_CTRL);
            assign w_wr_div[g]  = en & wr & (w_chan == CHW'(g)) & (w_reg == REG_DIV);

            tmr_chan #(
                .CNT_W (CNT_W)
            ) u_chan (
                .clk         (clk),
                .rst         (reset),
                .i_tick      (r_tick),
                .i_wr_ctrl   (w_wr_ctrl[g]),
                .i_wr_div    (w_wr_div[g]),
                .i_ctrl_data (data_in[CTRL_W-1:0]),
                .i_div_data  (data_in[CNT_W-1:0]),
                .o_ctrl      (w_ctrl[g]),
                .o_div       (w_div[g]),
                .o_count     (w_cnt[g]),
                .o_irq       (irq[g])
            );
        end
    endgenerate

    // Out-of-range channels and the reserved offset fall through to zero.
    always_comb begin
        data_out = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (w_chan == CHW'(i)) begin
                case (w_reg)
                    REG_CTRL: data_out = 32'(w_ctrl[i]);
                    REG_DIV:  data_out = 32'(w_div[i]);
                    REG_CNT:  data_out = 32'(w_cnt[i]);
                    default:  data_out = '0;
                endcase
            end
        end
    end

    assign wt = 1'b0;

endmodule
`default_nettype wire

// File: tb/tb_tmr_mc.sv
`default_nettype none
// ============================================================================
// Module   : tb_tmr_mc
// Function : Self-checking bench for tmr_mc (2 channels, prescale of 4)
// Revision : 1.0
// ============================================================================
module tb_tmr_mc;
    import tmr_pkg::*;

    localparam int NUM_CH   = 2;
    localparam int CNT_W    = 32;
    localparam int PRESCALE = 4;
    localparam int AW       = $clog2(NUM_CH) + 2;

    logic              clk     = 1'b0;
    logic              reset   = 1'b1;
    logic              en      = 1'b0;
    logic              wr      = 1'b0;
    logic [AW-1:0]     addr    = '0;
    logic [31:0]       data_in = '0;
    logic [31:0]       data_out;
    logic              wt;
    logic [NUM_CH-1:0] irq;

    always #5 clk = ~clk;

    tmr_mc #(
        .NUM_CH   (NUM_CH),
        .CNT_W    (CNT_W),
        .PRESCALE (PRESCALE)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
        .wr       (wr),
        .addr     (addr),
        .data_in  (data_in),
        .data_out (data_out),
        .wt       (wt),
        .irq      (irq)
    );

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;
    int rises  [NUM_CH];
    int rise_t [NUM_CH];
    logic [NUM_CH-1:0] irq_q = '0;
    logic wt_hi = 1'b0;

    typedef struct {
        string       name;
        logic [31:0] val;
    } sb_t;
    sb_t sb_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    // Irq edge monitor, sampled just after each rising clock edge.
    always @(posedge clk) begin
        #1;
        for (int i = 0; i < NUM_CH; i++) begin
            if (irq[i] && !irq_q[i]) begin
                rises[i]  <= rises[i] + 1;
                rise_t[i] <= cyc;
            end
        end
        irq_q <= irq;
        if (wt) wt_hi <= 1'b1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
        n_checks++;
        if (obs !== req) begin
            n_errors++;
            $display("FAIL %s: observed 0x%08h required 0x%08h", tag, obs, req);
        end
    endtask

    task automatic bus_wr(input int ch, input logic [1:0] rg, input logic [31:0] d);
        en      = 1'b1;
        wr      = 1'b1;
        addr    = AW'((ch << 2) | int'(rg));
        data_in = d;
        @(negedge clk);
        en = 1'b0;
        wr = 1'b0;
    endtask

    task automatic bus_rd(input int ch, input logic [1:0] rg, output logic [31:0] v, output int ts);
        en   = 1'b1;
        wr   = 1'b0;
        addr = AW'((ch << 2) | int'(rg));
        #1;
        v  = data_out;
        ts = cyc;
        en = 1'b0;
        @(negedge clk);
    endtask

    task automatic rd_exp(input int ch, input logic [1:0] rg, input logic [31:0] req, input string tag);
        sb_t         e;
        logic [31:0] v;
        int          ts;
        sb_q.push_back('{name: tag, val: req});
        bus_rd(ch, rg, v, ts);
        e = sb_q.pop_front();
        chk(e.name, v, e.val);
    endtask

    // Returns the cycle in which the register first takes value val after differing from it.
    task automatic poll_until(input int ch, input logic [1:0] rg, input logic [31:0] val,
                              input int limit, input string tag, output int t);
        logic [31:0] v;
        int          ts;
        bit          left  = 1'b0;
        bit          found = 1'b0;
        t = -1;
        for (int n = 0; n < limit; n++) begin
            bus_rd(ch, rg, v, ts);
            if (v != val) begin
                left = 1'b1;
            end else if (left) begin
                found = 1'b1;
                t     = ts;
                break;
            end
        end
        chk(tag, 32'(found), 32'd1);
    endtask

    task automatic wait_rise(input int ch, input int limit, input string tag, output int t);
        int snap = rises[ch];
        bit got  = 1'b0;
        t = -1;
        for (int n = 0; n < limit; n++) begin
            @(negedge clk);
            if (rises[ch] != snap) begin
                got = 1'b1;
                t   = rise_t[ch];
                break;
            end
        end
        chk(tag, 32'(got), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0, t1, t2, t3, r0, snap;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // Reset state and register map
        chk("rst_irq", 32'(irq), 32'd0);
        chk("rst_wt", 32'(wt), 32'd0);
        bus_wr(0, REG_CNT, 32'h1234_5678);
        rd_exp(0, REG_CNT, 32'hFFFF_FFFF, "cnt_ro");
        bus_wr(0, 2'd3, 32'hA5A5_A5A5);
        rd_exp(0, 2'd3, 32'h0, "rsvd_zero");
        rd_exp(0, REG_CTRL, 32'h4, "rst_ctrl0");
        rd_exp(0, REG_DIV, 32'hFFFF_FFFF, "rst_div0");
        rd_exp(1, REG_CTRL, 32'h4, "rst_ctrl1");

        // Periodic channel 1, divisor 3
        bus_wr(1, REG_DIV, 32'd3);
        bus_wr(1, REG_CTRL, 32'h6);
        rd_exp(1, REG_DIV, 32'd3, "div1_rb");
        wait_rise(1, 40, "t2_first_irq", t1);
        bus_wr(1, REG_CTRL, 32'h6);
        chk("t2_irq_clr", 32'(irq[1]), 32'd0);
        wait_rise(1, 20, "t2_second_irq", t2);
        chk("t2_period", 32'(t2 - t1), 32'd12);
        poll_until(1, REG_CNT, 32'd3, 20, "t2_cnt3", t0);
        poll_until(1, REG_CNT, 32'd2, 8, "t2_cnt2", t1);
        chk("t2_gap2", 32'(t1 - t0), 32'd4);
        poll_until(1, REG_CNT, 32'd1, 8, "t2_cnt1", t2);
        chk("t2_gap1", 32'(t2 - t1), 32'd4);
        poll_until(1, REG_CNT, 32'd3, 8, "t2_cnt_reload", t3);
        chk("t2_gap_reload", 32'(t3 - t2), 32'd4);

        // One-shot channel 0, divisor 2, aligned to a tick seen on channel 1
        poll_until(1, REG_CNT, 32'd2, 20, "t3_sync", t0);
        bus_wr(0, REG_DIV, 32'd2);
        bus_wr(0, REG_CTRL, 32'hE);
        wait_rise(0, 20, "t3_irq0", t1);
        chk("t3_latency", 32'(t1 - t0), 32'd9);
        rd_exp(0, REG_CTRL, 32'hB, "t3_ctrl");
        rd_exp(0, REG_CNT, 32'd2, "t3_cnt");
        bus_wr(0, REG_CTRL, 32'hA);
        chk("t3_irq0_clr", 32'(irq[0]), 32'd0);
        repeat (30) @(negedge clk);
        rd_exp(0, REG_CNT, 32'd2, "t3_cnt_hold");
        chk("t3_single_irq", 32'(rises[0]), 32'd1);

        // Stop channel 1 at count 2, then resume
        poll_until(1, REG_CNT, 32'd2, 20, "t4_sync", t0);
        bus_wr(1, REG_CTRL, 32'h2);
        chk("t4_irq_off", 32'(irq[1]), 32'd0);
        snap = rises[1];
        repeat (24) @(negedge clk);
        rd_exp(1, REG_CNT, 32'd2, "t4_frozen");
        chk("t4_no_alarm", 32'(rises[1] - snap), 32'd0);
        bus_wr(1, REG_CTRL, 32'h6);
        poll_until(1, REG_CNT, 32'd1, 10, "t4_resume1", t1);
        wait_rise(1, 10, "t4_alarm", t2);
        rd_exp(1, REG_CNT, 32'd3, "t4_reload");
        bus_wr(1, REG_CTRL, 32'h6);
        chk("t4_irq_clr", 32'(irq[1]), 32'd0);

        // CTRL write landing in the expiry cycle
        poll_until(1, REG_CNT, 32'd1, 20, "t5_sync", t0);
        repeat (3) @(negedge clk);
        bus_wr(1, REG_CTRL, 32'h2);
        rd_exp(1, REG_CTRL, 32'h3, "t5_expiry_wins");
        chk("t5_irq", 32'(irq[1]), 32'd1);

        // Reset mid-count with an alarm pending
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        r0 = cyc;
        chk("t6_irq", 32'(irq), 32'd0);
        rd_exp(1, REG_CTRL, 32'h4, "t6_ctrl1");
        rd_exp(1, REG_CNT, 32'hFFFF_FFFF, "t6_cnt1");
        poll_until(1, REG_CNT, 32'hFFFF_FFFE, 12, "t6_first_tick", t0);
        chk("t6_tick_delay", 32'(t0 - r0), 32'(PRESCALE + 1));
        rd_exp(1, REG_DIV, 32'hFFFF_FFFF, "t6_div1");

        chk("wt_low", 32'(wt_hi), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
